// File: rtl/sdfa_fire_scanner_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sdfa_fire_scanner_pkg
//  Description : Shared definitions for the SDFA neuron datapath.
//                - Default datapath widths and neuron count.
//                - Saturation bounds, shared with the adder stage.
//                - Fire-scanner state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package sdfa_fire_scanner_pkg;

   localparam int c_CAL_BIT           = 10;
   localparam int c_NEURON_SIZE_BIT   = 8;
   localparam int c_NUMBER_OF_NEURONS = 256;

   // Saturation bounds for a c_CAL_BIT two's-complement potential
   localparam logic [c_CAL_BIT-1:0] c_SAT_MAX = 10'b0111111111;
   localparam logic [c_CAL_BIT-1:0] c_SAT_MIN = 10'b1000000000;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_READ   = 3'd1,
      ST_LATCH  = 3'd2,
      ST_EVAL   = 3'd3,
      ST_FINISH = 3'd4
   } scan_state_t;

endpackage
`default_nettype wire

// File: rtl/sdfa_fire_scanner_subtractor.sv
`default_nettype none
// ============================================================================
//  Module      : sdfa_subtractor_module
//  Description : Combinational saturating subtract o_diff = i_a - i_b.
//                Counterpart of the adder-stage module; clamps to the
//                shared MAX/MIN bounds on signed overflow.
//  Ports       : i_a, i_b  - signed CAL_BIT operands
//                o_diff    - saturated signed CAL_BIT difference
//  Revision    : 1.0 - initial release
// ============================================================================
module sdfa_subtractor_module
   import sdfa_fire_scanner_pkg::*;
#(
   parameter int CAL_BIT = c_CAL_BIT
) (
   input  logic [CAL_BIT-1:0] i_a,
   input  logic [CAL_BIT-1:0] i_b,
   output logic [CAL_BIT-1:0] o_diff
);

   logic [CAL_BIT-1:0] w_raw;
   logic [CAL_BIT-1:0] w_max;
   logic [CAL_BIT-1:0] w_min;

   assign w_raw = i_a - i_b;

   // Use the bounds shared with the adder stage when widths agree, so both
   // stages clamp to exactly the same values.
   generate
      if (CAL_BIT == c_CAL_BIT) begin : g_shared_bounds
         assign w_max = c_SAT_MAX;
         assign w_min = c_SAT_MIN;
      end else begin : g_generic_bounds
         assign w_max = {1'b0, {(CAL_BIT-1){1'b1}}};
         assign w_min = {1'b1, {(CAL_BIT-1){1'b0}}};
      end
   endgenerate

   // Overflow is only possible when the operand signs differ; the result
   // sign then disagrees with the minuend sign.
   always_comb begin
      o_diff = w_raw;
      if (!i_a[CAL_BIT-1] && i_b[CAL_BIT-1] && w_raw[CAL_BIT-1]) begin
         o_diff = w_max;
      end else if (i_a[CAL_BIT-1] && !i_b[CAL_BIT-1] && !w_raw[CAL_BIT-1]) begin
         o_diff = w_min;
      end
   end

endmodule
`default_nettype wire

// File: rtl/sdfa_fire_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : sdfa_fire_scanner
//  Description : Post-accumulation fire stage. Scans every neuron potential,
//                subtracts the leak, compares against the threshold, emits
//                firing neuron indices on a valid/ready port and writes back
//                the (possibly threshold-reduced) potential.
//  Ports       : clk, rst_n              - clock, async active-low reset
//                start, threshold, leak  - pass request and its parameters
//                busy, done              - pass status / end-of-pass pulse
//                mem_*                   - neuron memory read/write port
//                spike_valid/ready/id    - spike output handshake
//                spike_count             - spikes issued in current/last pass
//  Revision    : 1.0 - initial release
// ============================================================================
module sdfa_fire_scanner
   import sdfa_fire_scanner_pkg::*;
#(
   parameter int CAL_BIT           = c_CAL_BIT,
   parameter int NUMBER_OF_NEURONS = c_NUMBER_OF_NEURONS,
   parameter int NEURON_SIZE_BIT   = c_NEURON_SIZE_BIT
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start,
   input  logic [CAL_BIT-1:0]         threshold,
   input  logic [CAL_BIT-1:0]         leak,
   output logic                       busy,
   output logic                       done,
   output logic                       mem_rd_en,
   output logic [NEURON_SIZE_BIT-1:0] mem_addr,
   input  logic [CAL_BIT-1:0]         mem_rd_data,
   output logic                       mem_wr_en,
   output logic [CAL_BIT-1:0]         mem_wr_data,
   output logic                       spike_valid,
   input  logic                       spike_ready,
   output logic [NEURON_SIZE_BIT-1:0] spike_id,
   output logic [NEURON_SIZE_BIT:0]   spike_count
);

   localparam logic [NEURON_SIZE_BIT-1:0] c_LAST_IDX = NEURON_SIZE_BIT'(NUMBER_OF_NEURONS - 1);

   scan_state_t                r_state;
   scan_state_t                w_next_state;
   logic [NEURON_SIZE_BIT-1:0] r_idx;
   logic [CAL_BIT-1:0]         r_thr;
   logic [CAL_BIT-1:0]         r_leak;
   logic [CAL_BIT-1:0]         r_p;
   logic                       r_spike_valid;
   logic [NEURON_SIZE_BIT-1:0] r_spike_id;
   logic [NEURON_SIZE_BIT:0]   r_spike_count;

   logic [CAL_BIT-1:0]         w_v;
   logic [CAL_BIT-1:0]         w_residue;
   logic                       w_fire;
   logic                       w_slot_free;
   logic                       w_capture;
   logic                       w_commit;
   logic                       w_push;

   // Leaked potential, then the post-fire residue
   sdfa_subtractor_module #(.CAL_BIT(CAL_BIT)) u_leak_sub (
      .i_a    (r_p),
      .i_b    (r_leak),
      .o_diff (w_v)
   );

   sdfa_subtractor_module #(.CAL_BIT(CAL_BIT)) u_thr_sub (
      .i_a    (w_v),
      .i_b    (r_thr),
      .o_diff (w_residue)
   );

   assign w_fire      = $signed(w_v) >= $signed(r_thr);
   // The spike register can take a new index if empty or draining this cycle
   assign w_slot_free = !r_spike_valid || spike_ready;

   always_comb begin
      w_next_state = r_state;
      mem_rd_en    = 1'b0;
      mem_wr_en    = 1'b0;
      mem_wr_data  = '0;
      done         = 1'b0;
      w_capture    = 1'b0;
      w_commit     = 1'b0;
      w_push       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_capture    = 1'b1;
               w_next_state = ST_READ;
            end
         end
         ST_READ: begin
            mem_rd_en    = 1'b1;
            w_next_state = ST_LATCH;
         end
         ST_LATCH: begin
            w_next_state = ST_EVAL;
         end
         ST_EVAL: begin
            // A firing neuron waits here, unwritten, until its spike can be
            // pushed, so write-back and spike always commit together.
            if (w_fire) begin
               if (w_slot_free) begin
                  mem_wr_en   = 1'b1;
                  mem_wr_data = w_residue;
                  w_push      = 1'b1;
                  w_commit    = 1'b1;
               end
            end else begin
               mem_wr_en   = 1'b1;
               mem_wr_data = w_v;
               w_commit    = 1'b1;
            end
            if (w_commit) begin
               w_next_state = (r_idx == c_LAST_IDX) ? ST_FINISH : ST_READ;
            end
         end
         ST_FINISH: begin
            if (!r_spike_valid) begin
               done         = 1'b1;
               w_next_state = ST_IDLE;
            end
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= ST_IDLE;
         r_idx         <= '0;
         r_thr         <= '0;
         r_leak        <= '0;
         r_p           <= '0;
         r_spike_valid <= 1'b0;
         r_spike_id    <= '0;
         r_spike_count <= '0;
      end else begin
         r_state <= w_next_state;
         if (w_capture) begin
            r_thr         <= threshold;
            r_leak        <= leak;
            r_idx         <= '0;
            r_spike_count <= '0;
         end else if (w_commit && (r_idx != c_LAST_IDX)) begin
            r_idx <= r_idx + 1'b1;
         end
         if (r_state == ST_LATCH) begin
            r_p <= mem_rd_data;
         end
         if (w_push) begin
            r_spike_valid <= 1'b1;
            r_spike_id    <= r_idx;
            r_spike_count <= r_spike_count + 1'b1;
         end else if (r_spike_valid && spike_ready) begin
            r_spike_valid <= 1'b0;
         end
      end
   end

   assign busy        = (r_state != ST_IDLE);
   assign mem_addr    = r_idx;
   assign spike_valid = r_spike_valid;
   assign spike_id    = r_spike_id;
   assign spike_count = r_spike_count;

endmodule
`default_nettype wire
